// File: rtl/caption_rle_decoder_if.sv
// Bus bundle for the caption RLE decoder.
// Groups the start/base-address control, the synchronous ROM read port,
// and the pixel stream (valid/ready plus index, coordinates and frame
// markers) so the decoder and its neighbours connect through one port.
//   master : the decoder side (drives ROM read, pixel stream, status)
//   slave  : the environment side (drives start, base, ROM data, ready)
interface caption_rle_decoder_if #(
    parameter int ADDR_W = 16,
    parameter int X_W    = 9,
    parameter int Y_W    = 7
);

    logic              i_start;
    logic [ADDR_W-1:0] i_base_addr;
    logic              o_rom_rd;
    logic [ADDR_W-1:0] o_rom_addr;
    logic [7:0]        i_rom_data;
    logic              o_valid;
    logic              i_ready;
    logic [3:0]        o_idx;
    logic [X_W-1:0]    o_x;
    logic [Y_W-1:0]    o_y;
    logic              o_last;
    logic              o_busy;
    logic              o_done;

    modport master (
        input  i_start, i_base_addr, i_rom_data, i_ready,
        output o_rom_rd, o_rom_addr, o_valid, o_idx, o_x, o_y,
               o_last, o_busy, o_done
    );

    modport slave (
        output i_start, i_base_addr, i_rom_data, i_ready,
        input  o_rom_rd, o_rom_addr, o_valid, o_idx, o_x, o_y,
               o_last, o_busy, o_done
    );

endinterface

// File: rtl/caption_rle_decoder.sv
// Run-length decoder for caption bitmaps.
// Reads {run[7:4], idx[3:0]} code bytes from a synchronous ROM (data one
// cycle after the read strobe) and expands each into run+1 palette indices
// on a valid/ready stream with raster x/y, a last-pixel marker, and
// busy/done status. Index 0 passes through untouched (transparent).
// Ports:
//   i_clk  : clock
//   i_rst  : synchronous active-high reset
//   bus    : caption_rle_decoder_if.master (start/base, ROM port, stream)
module caption_rle_decoder #(
    parameter int ADDR_W = 16,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 64,
    parameter int X_W    = 9,
    parameter int Y_W    = 7
) (
    input logic                   i_clk,
    input logic                   i_rst,
    caption_rle_decoder_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        run_cnt;
    logic [3:0]        idx_reg;
    logic [X_W-1:0]    x_cnt;
    logic [Y_W-1:0]    y_cnt;
    logic              at_row_end;
    logic              at_frame_end;
    logic              xfer;

    assign at_row_end   = (x_cnt == X_LAST);
    assign at_frame_end = at_row_end && (y_cnt == Y_LAST);
    assign xfer         = (state == ST_EMIT) && bus.i_ready;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The frame-end test takes priority over the run
    // count so an overlong run is cut off without fetching another byte.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (bus.i_start) state_next = ST_FETCH;
            ST_FETCH: state_next = ST_WAIT;
            ST_WAIT:  state_next = ST_EMIT;
            ST_EMIT: begin
                if (xfer) begin
                    if (at_frame_end) begin
                        state_next = ST_DONE;
                    end else if (run_cnt == 4'd0) begin
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Datapath registers: code-byte address, run/index of the current
    // run, and raster position. y wraps with x at frame end so the
    // coordinates read (0,0) again once the frame is finished.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_reg <= '0;
            run_cnt  <= '0;
            idx_reg  <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        addr_reg <= bus.i_base_addr;
                        run_cnt  <= '0;
                        x_cnt    <= '0;
                        y_cnt    <= '0;
                    end
                end
                ST_WAIT: begin
                    run_cnt  <= bus.i_rom_data[7:4];
                    idx_reg  <= bus.i_rom_data[3:0];
                    addr_reg <= addr_reg + ADDR_W'(1);
                end
                ST_EMIT: begin
                    if (xfer) begin
                        run_cnt <= run_cnt - 4'd1;
                        if (at_row_end) begin
                            x_cnt <= '0;
                            y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + Y_W'(1);
                        end else begin
                            x_cnt <= x_cnt + X_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode. The ROM address is only presented alongside the read
    // strobe; index and coordinates come straight from the registers so
    // they stay put while the stream is stalled.
    always_comb begin
        bus.o_rom_rd   = 1'b0;
        bus.o_rom_addr = '0;
        bus.o_valid    = 1'b0;
        bus.o_idx      = idx_reg;
        bus.o_x        = x_cnt;
        bus.o_y        = y_cnt;
        bus.o_last     = 1'b0;
        bus.o_busy     = 1'b0;
        bus.o_done     = 1'b0;
        case (state)
            ST_FETCH: begin
                bus.o_rom_rd   = 1'b1;
                bus.o_rom_addr = addr_reg;
                bus.o_busy     = 1'b1;
            end
            ST_WAIT: begin
                bus.o_busy = 1'b1;
            end
            ST_EMIT: begin
                bus.o_valid = 1'b1;
                bus.o_last  = at_frame_end;
                bus.o_busy  = 1'b1;
            end
            ST_DONE: begin
                bus.o_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_caption_rle_decoder.sv
// Self-checking bench for caption_rle_decoder.
// Two decoder instances (4x1 and 4x2 frames) share one ROM image; a
// per-frame model expands the ROM bytes into expected pixel beats and
// expected ROM read addresses, which are popped as the DUT produces them.
module tb_caption_rle_decoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    caption_rle_decoder_if #(.ADDR_W(16), .X_W(9), .Y_W(7)) bus_a ();
    caption_rle_decoder_if #(.ADDR_W(16), .X_W(9), .Y_W(7)) bus_b ();

    logic        start_a;
    logic        start_b;
    logic        ready;
    logic [15:0] base;
    logic [7:0]  rom_data_a;
    logic [7:0]  rom_data_b;
    logic [7:0]  rom [256];
    logic        sel;

    assign bus_a.i_start     = start_a;
    assign bus_b.i_start     = start_b;
    assign bus_a.i_base_addr = base;
    assign bus_b.i_base_addr = base;
    assign bus_a.i_ready     = ready;
    assign bus_b.i_ready     = ready;
    assign bus_a.i_rom_data  = rom_data_a;
    assign bus_b.i_rom_data  = rom_data_b;

    caption_rle_decoder #(
        .ADDR_W(16), .WIDTH(4), .HEIGHT(1), .X_W(9), .Y_W(7)
    ) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_a.master)
    );

    caption_rle_decoder #(
        .ADDR_W(16), .WIDTH(4), .HEIGHT(2), .X_W(9), .Y_W(7)
    ) dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_b.master)
    );

    // Synchronous ROM: data valid one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        rom_data_a <= bus_a.o_rom_rd ? rom[bus_a.o_rom_addr[7:0]] : 8'hEE;
        rom_data_b <= bus_b.o_rom_rd ? rom[bus_b.o_rom_addr[7:0]] : 8'hEE;
    end

    logic        mon_valid;
    logic [3:0]  mon_idx;
    logic [8:0]  mon_x;
    logic [6:0]  mon_y;
    logic        mon_last;
    logic        mon_busy;
    logic        mon_done;
    logic        mon_rom_rd;
    logic [15:0] mon_rom_addr;
    logic [40:0] outs_a;
    logic [40:0] outs_b;

    assign mon_valid    = sel ? bus_b.o_valid    : bus_a.o_valid;
    assign mon_idx      = sel ? bus_b.o_idx      : bus_a.o_idx;
    assign mon_x        = sel ? bus_b.o_x        : bus_a.o_x;
    assign mon_y        = sel ? bus_b.o_y        : bus_a.o_y;
    assign mon_last     = sel ? bus_b.o_last     : bus_a.o_last;
    assign mon_busy     = sel ? bus_b.o_busy     : bus_a.o_busy;
    assign mon_done     = sel ? bus_b.o_done     : bus_a.o_done;
    assign mon_rom_rd   = sel ? bus_b.o_rom_rd   : bus_a.o_rom_rd;
    assign mon_rom_addr = sel ? bus_b.o_rom_addr : bus_a.o_rom_addr;

    assign outs_a = {bus_a.o_valid, bus_a.o_idx, bus_a.o_x, bus_a.o_y, bus_a.o_last,
                     bus_a.o_busy, bus_a.o_done, bus_a.o_rom_rd, bus_a.o_rom_addr};
    assign outs_b = {bus_b.o_valid, bus_b.o_idx, bus_b.o_x, bus_b.o_y, bus_b.o_last,
                     bus_b.o_busy, bus_b.o_done, bus_b.o_rom_rd, bus_b.o_rom_addr};

    typedef struct packed {
        logic [3:0] idx;
        logic [8:0] x;
        logic [6:0] y;
        logic       last;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] addr_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          rd_count = 0;
    int          exp_reads = 0;
    int          beats_seen = 0;
    bit          done_due = 1'b0;
    bit          frame_done = 1'b0;
    bit          seen_valid = 1'b0;
    bit          stall_prev = 1'b0;
    logic [19:0] held;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Expand the ROM image from addr into expected beats and read addresses.
    task automatic buildModel(input logic [15:0] addr, input int w, input int h);
        int          pos;
        logic [15:0] a;
        logic [7:0]  code;
        beat_t       e;
        pos = 0;
        a = addr;
        exp_reads = 0;
        while (pos < w * h) begin
            code = rom[a[7:0]];
            addr_q.push_back(a);
            exp_reads++;
            for (int k = 0; k <= int'(code[7:4]) && pos < w * h; k++) begin
                e.idx  = code[3:0];
                e.x    = 9'(pos % w);
                e.y    = 7'(pos / w);
                e.last = (pos == w * h - 1);
                exp_q.push_back(e);
                pos++;
            end
            a = a + 16'd1;
        end
    endtask

    // Negedge monitor: ROM reads, pixel transfers, stall stability, done.
    task automatic sampleOutputs();
        beat_t e;
        cyc++;
        if (rst) return;
        if (done_due) begin
            checkOutput("done_pulse", mon_done, 1);
            done_due = 1'b0;
            frame_done = 1'b1;
        end else if (mon_done) begin
            checkOutput("spurious_done", mon_done, 0);
        end
        if (stall_prev) begin
            checkOutput("stall_hold", {mon_valid, mon_idx, mon_x, mon_y}, {1'b1, held});
        end
        stall_prev = mon_valid && !ready;
        held = {mon_idx, mon_x, mon_y};
        if (mon_rom_rd) begin
            rd_count++;
            if (addr_q.size() == 0) begin
                checkOutput("rom_extra_read", {1'b1, mon_rom_addr}, 0);
            end else begin
                checkOutput("rom_addr", mon_rom_addr, addr_q.pop_front());
            end
        end
        if (mon_valid && !seen_valid) begin
            seen_valid = 1'b1;
            checkOutput("first_valid_latency", cyc - start_cyc, 3);
        end
        if (mon_valid && ready) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                checkOutput("extra_beat", {1'b1, mon_idx, mon_x, mon_y}, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("beat_idx", mon_idx, e.idx);
                checkOutput("beat_x", mon_x, e.x);
                checkOutput("beat_y", mon_y, e.y);
                checkOutput("beat_last", mon_last, e.last);
                if (e.last) done_due = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sampleOutputs();
        @(posedge clk);
        #1;
    endtask

    // Load the model for the selected instance and pulse its start.
    task automatic applyStimulus(input bit which, input logic [15:0] addr);
        sel = which;
        base = addr;
        rd_count = 0;
        beats_seen = 0;
        seen_valid = 1'b0;
        frame_done = 1'b0;
        buildModel(addr, 4, which ? 2 : 1);
        if (which) start_b = 1'b1;
        else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        start_cyc = cyc;
    endtask

    // mode 0: always ready, 1: ready 1,0,0 repeating, 2: random.
    task automatic runFrame(input bit which, input logic [15:0] addr,
                            input int mode, input bit inject);
        int n;
        bit injected;
        n = 0;
        injected = 1'b0;
        ready = 1'b1;
        applyStimulus(which, addr);
        while (!frame_done && n < 300) begin
            case (mode)
                1:       ready = (n % 3 == 0);
                2:       ready = 1'($urandom_range(0, 1));
                default: ready = 1'b1;
            endcase
            if (inject && seen_valid && !injected) begin
                base = 16'h0040;
                if (which) start_b = 1'b1;
                else start_a = 1'b1;
                injected = 1'b1;
            end
            tick();
            start_a = 1'b0;
            start_b = 1'b0;
            n++;
        end
        if (!frame_done) checkOutput("frame_timeout", n, 0);
        ready = 1'b1;
        tick();
        checkOutput("idle_after_done", {mon_busy, mon_valid}, 0);
        checkOutput("beats_left", exp_q.size(), 0);
        checkOutput("rom_read_count", rd_count, exp_reads);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        ready = 1'b0;
        base = '0;
        sel = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h99;
        rom[8'h00] = 8'h23;
        rom[8'h01] = 8'h05;
        rom[8'h10] = 8'h32;
        rom[8'h20] = 8'h71;
        rom[8'h30] = 8'hF0;
        rom[8'h31] = 8'h55;
        rom[8'h40] = 8'h77;
        rom[8'h50] = 8'h14;
        rom[8'h51] = 8'h2A;
        rom[8'h52] = 8'h3B;
        for (int i = 8'h60; i < 8'h68; i++) rom[i] = 8'($urandom_range(0, 255));

        tick();
        tick();
        checkOutput("reset_outs_a", outs_a, 0);
        checkOutput("reset_outs_b", outs_b, 0);
        rst = 1'b0;
        tick();

        $display("[TB] basic decode");
        runFrame(1'b0, 16'h0000, 0, 1'b0);
        $display("[TB] row wrap");
        runFrame(1'b1, 16'h0020, 0, 1'b0);
        $display("[TB] backpressure");
        runFrame(1'b1, 16'h0020, 1, 1'b0);
        $display("[TB] truncation and transparency");
        runFrame(1'b0, 16'h0030, 0, 1'b0);

        $display("[TB] reset mid-frame");
        ready = 1'b1;
        applyStimulus(1'b0, 16'h0000);
        n = 0;
        while (beats_seen < 1 && n < 50) begin
            tick();
            n++;
        end
        checkOutput("midrst_first_beat", beats_seen, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        done_due = 1'b0;
        stall_prev = 1'b0;
        frame_done = 1'b0;
        @(negedge clk);
        checkOutput("midrst_outs", outs_a, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("midrst_no_done", frame_done, 0);
        runFrame(1'b0, 16'h0010, 0, 1'b0);

        $display("[TB] start ignored while busy");
        runFrame(1'b1, 16'h0050, 0, 1'b1);
        $display("[TB] random ready");
        runFrame(1'b1, 16'h0060, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
